spi_slave_word: RTL and testbench

- SPI responder for the 16-bit word link that the FPGA-side spi_master drives toward the motor-board side.
- Oversamples SCK, SSN and MOSI in the system clock domain, deserialises MOSI words and serialises MISO words.
- Settings match the master: 16-bit words, MSB first, CPOL=0, CPHA=1.
- Used on the motor-board FPGA and as the bench counterpart of spi_master; the user logic sits behind simple rx/tx word handshakes.

---
 rtl/spi_link_pkg.sv | 22 ++
 rtl/spi_slave_word_if.sv | 57 +++++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave_word.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave_word.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_link_pkg.sv
// ---------------------------------------------------------------------------
// spi_link_pkg
// Shared constants for the 16-bit FPGA <-> motor-board SPI word link.
//   SPI_WORD_W    : bits per word on the link
//   SPI_CPOL/CPHA : clock mode shared by spi_master and spi_slave_word
//   SPI_IDLE_WORD : word returned when the responder has nothing queued
//   ST_*          : responder FSM state encodings
// ---------------------------------------------------------------------------
package spi_link_pkg;

    localparam int                    SPI_WORD_W    = 16;
    localparam logic                  SPI_CPOL      = 1'b0;
    localparam logic                  SPI_CPHA      = 1'b1;
    localparam logic [SPI_WORD_W-1:0] SPI_IDLE_WORD = 16'h0000;

    typedef logic [1:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 2'd0;
    localparam spi_state_t ST_LOAD  = 2'd1;
    localparam spi_state_t ST_SHIFT = 2'd2;

endpackage

// File: rtl/spi_slave_word_if.sv
// ---------------------------------------------------------------------------
// spi_slave_word_if
// Bundles the SPI pins and the user-side rx/tx word handshakes of
// spi_slave_word. Signal suffixes are from the responder's point of view.
//   slave  modport : used by spi_slave_word
//   master modport : used by the SPI master / user logic side
// Optional status signals exist only when SPI_SLAVE_STATUS_EN is defined.
// ---------------------------------------------------------------------------
interface spi_slave_word_if
    import spi_link_pkg::*;
#(
    parameter int WORD_W = SPI_WORD_W,
    parameter int IDX_W  = 8
);

    logic              sck_i;
    logic              ssn_i;
    logic              mosi_i;
    logic              miso_o;
    logic              miso_oe_o;
    logic [WORD_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [WORD_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic [IDX_W-1:0]  word_idx_o;
    logic              frame_start_o;
    logic              frame_end_o;
    logic              abort_o;
`ifdef SPI_SLAVE_STATUS_EN
    logic              underrun_o;
    logic              overrun_o;
    logic              status_clr_i;
    logic [IDX_W-1:0]  frame_words_o;
`endif

    modport slave (
        input  sck_i, ssn_i, mosi_i, tx_data_i, tx_valid_i,
`ifdef SPI_SLAVE_STATUS_EN
        input  status_clr_i,
        output underrun_o, overrun_o, frame_words_o,
`endif
        output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
        output word_idx_o, frame_start_o, frame_end_o, abort_o
    );

    modport master (
        output sck_i, ssn_i, mosi_i, tx_data_i, tx_valid_i,
`ifdef SPI_SLAVE_STATUS_EN
        output status_clr_i,
        input  underrun_o, overrun_o, frame_words_o,
`endif
        input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
        input  word_idx_o, frame_start_o, frame_end_o, abort_o
    );

endinterface

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for an asynchronous pin followed by a history flop;
// rise_o/fall_o are single-cycle strobes of the synchronised level.
//   clock, reset_n : system clock, async active-low reset
//   d_i            : asynchronous input pin
//   rise_o/fall_o  : edge strobes in the clock domain
// RESET_VAL sets the idle level so no false edge appears after reset.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_slave_word.sv
// ---------------------------------------------------------------------------
// spi_slave_word
// SPI responder for the 16-bit word link (MSB first, CPOL=0, CPHA=1).
// SCK/SSN/MOSI are oversampled in the system clock domain (clock >= 8x SCK).
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   bus (slave)    : SPI pins, tx holding handshake, rx word strobe,
//                    word index and frame start/end/abort pulses
// Optional: define SPI_SLAVE_STATUS_EN to add sticky underrun/overrun flags,
// status_clr_i and the frame_words_o count of the last frame.
// ---------------------------------------------------------------------------
module spi_slave_word
    import spi_link_pkg::*;
#(
    parameter int                WORD_W      = SPI_WORD_W,
    parameter logic [WORD_W-1:0] IDLE_WORD   = WORD_W'(SPI_IDLE_WORD),
    parameter int                SYNC_STAGES = 2,
    parameter int                IDX_W       = 8
) (
    input logic             clock,
    input logic             reset_n,
    spi_slave_word_if.slave bus
);

    localparam int                CNT_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);

    logic sck_rise, sck_fall, ssn_rise, ssn_fall, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sck (
        .clock(clock), .reset_n(reset_n), .d_i(bus.sck_i),
        .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssn (
        .clock(clock), .reset_n(reset_n), .d_i(bus.ssn_i),
        .rise_o(ssn_rise), .fall_o(ssn_fall)
    );

    // MOSI has the same depth as SCK so a bit lines up with its sampling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) mosi_sync_q <= '0;
        else          mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi_i};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [WORD_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d, load_word;
    logic              hold_valid_q, hold_valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d, word_idx_q, word_idx_d;
    logic              miso_q, miso_d, oe_q, oe_d, rx_valid_q, rx_valid_d;
    logic              fstart_q, fstart_d, fend_q, fend_d, abort_q, abort_d;
    logic              load_evt;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        idx_d        = idx_q;
        word_idx_d   = word_idx_q;
        rx_data_d    = rx_data_q;
        miso_d       = miso_q;
        oe_d         = oe_q;
        rx_valid_d   = 1'b0;
        fstart_d     = 1'b0;
        fend_d       = 1'b0;
        abort_d      = 1'b0;
        load_evt     = 1'b0;
        load_word    = hold_valid_q ? hold_q : IDLE_WORD;

        unique case (state_q)
            ST_IDLE: begin
                oe_d = 1'b0;
                if (ssn_fall) begin
                    fstart_d = 1'b1;
                    idx_d    = '0;
                    oe_d     = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bitcnt_d = '0;
                if (sck_rise) begin
                    load_evt   = 1'b1;
                    tx_shift_d = load_word;
                    miso_d     = load_word[WORD_W-1];
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sck_fall) begin
                    rx_shift_d = {rx_shift_q[WORD_W-2:0], mosi_s};
                    bitcnt_d   = bitcnt_q + 1'b1;
                    if (bitcnt_q == LAST_BIT) begin
                        rx_data_d  = {rx_shift_q[WORD_W-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        word_idx_d = idx_q;
                        if (idx_q != '1) idx_d = idx_q + 1'b1;
                        state_d    = ST_LOAD;
                    end
                end else if (sck_rise && (bitcnt_q < FULL_CNT)) begin
                    tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
                    miso_d     = tx_shift_q[WORD_W-2];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Deselect is applied after the word logic so a final fall on the
        // same clock still completes its word and does not count as abort.
        if (ssn_rise && (state_q != ST_IDLE)) begin
            fend_d  = 1'b1;
            oe_d    = 1'b0;
            state_d = ST_IDLE;
            abort_d = (bitcnt_d != '0) && (bitcnt_d != FULL_CNT);
        end

        // A load consumes an occupied register; capture only fills an empty
        // one, so the two never fight over hold_valid.
        if (load_evt && hold_valid_q) hold_valid_d = 1'b0;
        if (bus.tx_valid_i && !hold_valid_q) begin
            hold_d       = bus.tx_data_i;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= '0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            idx_q        <= '0;
            word_idx_q   <= '0;
            rx_data_q    <= '0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            rx_valid_q   <= 1'b0;
            fstart_q     <= 1'b0;
            fend_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            idx_q        <= idx_d;
            word_idx_q   <= word_idx_d;
            rx_data_q    <= rx_data_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            rx_valid_q   <= rx_valid_d;
            fstart_q     <= fstart_d;
            fend_q       <= fend_d;
            abort_q      <= abort_d;
        end
    end

    assign bus.miso_o        = miso_q;
    assign bus.miso_oe_o     = oe_q;
    assign bus.tx_ready_o    = ~hold_valid_q;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.rx_valid_o    = rx_valid_q;
    assign bus.word_idx_o    = word_idx_q;
    assign bus.frame_start_o = fstart_q;
    assign bus.frame_end_o   = fend_q;
    assign bus.abort_o       = abort_q;

`ifdef SPI_SLAVE_STATUS_EN
    logic             underrun_q, overrun_q;
    logic [IDX_W-1:0] frame_words_q;

    // Sticky flags; an explicit clear wins over a new event on the same clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
            frame_words_q <= '0;
        end else begin
            if (bus.status_clr_i) begin
                underrun_q <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                if (load_evt && !hold_valid_q) underrun_q <= 1'b1;
                if (bus.tx_valid_i && hold_valid_q && (state_q != ST_IDLE))
                    overrun_q <= 1'b1;
            end
            if (fend_d) frame_words_q <= idx_d;
        end
    end

    assign bus.underrun_o    = underrun_q;
    assign bus.overrun_o     = overrun_q;
    assign bus.frame_words_o = frame_words_q;
`endif

endmodule

// File: tb/tb_spi_slave_word.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_word
// Self-checking bench for spi_slave_word: table of single-word frames, hand
// sequences for multi-word, abort, simultaneous deselect and async reset,
// then jittered random frames against a queue-based reference of the link.
// ---------------------------------------------------------------------------
module tb_spi_slave_word;

    logic clock;
    logic reset_n;

    spi_slave_word_if #(.WORD_W(16), .IDX_W(8)) bus ();

    spi_slave_word #(
        .WORD_W(16), .IDLE_WORD(16'h0000), .SYNC_STAGES(2), .IDX_W(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] txFeed[$];
    logic [15:0] rxDataQ[$];
    logic [7:0]  rxIdxQ[$];
    int          fsCount, feCount, abCount;

    typedef struct {
        logic [15:0] mosiW;
        logic [15:0] txW;
        bit          queueTx;
        logic [15:0] expRx;
        logic [15:0] expMiso;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] mArr[6];
    logic [15:0] tArr[6];
    logic [15:0] got;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic int halfPeriod(input bit jit);
        return jit ? 3 + int'($urandom_range(0, 2)) : 4;
    endfunction

    // Offers one queued word for a single cycle whenever the holding register is free.
    initial begin
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = '0;
        forever begin
            @(negedge clock);
            if (!reset_n || bus.tx_valid_i) begin
                bus.tx_valid_i = 1'b0;
            end else if (bus.tx_ready_o && (txFeed.size() > 0)) begin
                bus.tx_data_i  = txFeed.pop_front();
                bus.tx_valid_i = 1'b1;
            end
        end
    end

    // Output monitor, sampled on the inactive clock edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.rx_valid_o) begin
                    rxDataQ.push_back(bus.rx_data_o);
                    rxIdxQ.push_back(bus.word_idx_o);
                end
                if (bus.frame_start_o) fsCount++;
                if (bus.frame_end_o)   feCount++;
                if (bus.abort_o)       abCount++;
            end
        end
    end

    task automatic clearMon();
        rxDataQ.delete();
        rxIdxQ.delete();
        fsCount = 0;
        feCount = 0;
        abCount = 0;
    endtask

    task automatic frameBegin();
        bus.ssn_i = 1'b0;
        waitClocks(4);
    endtask

    task automatic frameEnd();
        waitClocks(4);
        bus.ssn_i = 1'b1;
        waitClocks(6);
    endtask

    // Master side of one word: drive MOSI on rise, sample MISO on fall.
    task automatic spiWord(input logic [15:0] mosiW, input int nBits, input bit jit,
                           input bit ssnWithLastFall, output logic [15:0] misoW);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < nBits; i++) begin
            bus.sck_i  = 1'b1;
            bus.mosi_i = mosiW[15-i];
            waitClocks(halfPeriod(jit));
            acc       = {acc[14:0], bus.miso_o};
            bus.sck_i = 1'b0;
            if (ssnWithLastFall && (i == nBits - 1)) bus.ssn_i = 1'b1;
            waitClocks(halfPeriod(jit));
        end
        misoW = acc;
    endtask

    task automatic applyStimulus(input vec_t v, output logic [15:0] misoW);
        if (v.queueTx) txFeed.push_back(v.txW);
        waitClocks(4);
        clearMon();
        frameBegin();
        spiWord(v.mosiW, 16, 1'b0, 1'b0, misoW);
        frameEnd();
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.sck_i        = 1'b0;
        bus.ssn_i        = 1'b1;
        bus.mosi_i       = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
        bus.status_clr_i = 1'b0;
`endif
        clearMon();

        vecs[0] = '{16'hA5C3, 16'h1234, 1'b1, 16'hA5C3, 16'h1234};
        vecs[1] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF};
        vecs[2] = '{16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE};
        vecs[3] = '{16'h3C96, 16'hC0DE, 1'b1, 16'h3C96, 16'hC0DE};
        vecs[4] = '{16'h5A5A, 16'hDEAD, 1'b0, 16'h5A5A, 16'h0000};

        // Reset state.
        waitClocks(3);
        checkOutput("reset miso",     bus.miso_o,        0);
        checkOutput("reset miso_oe",  bus.miso_oe_o,     0);
        checkOutput("reset tx_ready", bus.tx_ready_o,    1);
        checkOutput("reset rx_data",  bus.rx_data_o,     0);
        checkOutput("reset rx_valid", bus.rx_valid_o,    0);
        checkOutput("reset word_idx", bus.word_idx_o,    0);
        checkOutput("reset pulses",   {bus.frame_start_o, bus.frame_end_o, bus.abort_o}, 0);
        reset_n = 1'b1;
        waitClocks(3);

        // Single-word frames from the table.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], got);
            checkOutput($sformatf("vec%0d miso word", i), got, vecs[i].expMiso);
            checkOutput($sformatf("vec%0d rx count", i), rxDataQ.size(), 1);
            if (rxDataQ.size() > 0) begin
                checkOutput($sformatf("vec%0d rx data", i), rxDataQ[0], vecs[i].expRx);
                checkOutput($sformatf("vec%0d word idx", i), rxIdxQ[0], 0);
            end
            checkOutput($sformatf("vec%0d frame start", i), fsCount, 1);
            checkOutput($sformatf("vec%0d frame end", i), feCount, 1);
            checkOutput($sformatf("vec%0d abort", i), abCount, 0);
            checkOutput($sformatf("vec%0d oe after", i), bus.miso_oe_o, 0);
`ifdef SPI_SLAVE_STATUS_EN
            checkOutput($sformatf("vec%0d underrun", i), bus.underrun_o, vecs[i].queueTx ? 0 : 1);
            bus.status_clr_i = 1'b1;
            waitClocks(1);
            bus.status_clr_i = 1'b0;
            waitClocks(1);
            checkOutput($sformatf("vec%0d underrun clr", i), bus.underrun_o, 0);
`endif
        end

        // Abort after 9 falls, then a clean frame.
        waitClocks(4);
        clearMon();
        frameBegin();
        spiWord(16'h1234, 9, 1'b0, 1'b0, got);
        frameEnd();
        checkOutput("abort pulse",    abCount, 1);
        checkOutput("abort rx count", rxDataQ.size(), 0);
        checkOutput("abort frame end", feCount, 1);
        checkOutput("abort oe",       bus.miso_oe_o, 0);
        clearMon();
        frameBegin();
        spiWord(16'hFFFF, 16, 1'b0, 1'b0, got);
        frameEnd();
        checkOutput("post-abort rx count", rxDataQ.size(), 1);
        if (rxDataQ.size() > 0) checkOutput("post-abort rx data", rxDataQ[0], 16'hFFFF);
        checkOutput("post-abort abort", abCount, 0);

        // SSN rises together with the final SCK fall.
        clearMon();
        frameBegin();
        spiWord(16'h6E17, 16, 1'b0, 1'b1, got);
        waitClocks(6);
        checkOutput("simul rx count", rxDataQ.size(), 1);
        if (rxDataQ.size() > 0) checkOutput("simul rx data", rxDataQ[0], 16'h6E17);
        checkOutput("simul frame end", feCount, 1);
        checkOutput("simul abort", abCount, 0);

        // Three-word frame with the holding register refilled between words.
        txFeed.push_back(16'hAAA1);
        txFeed.push_back(16'hBBB2);
        txFeed.push_back(16'hCCC3);
        waitClocks(4);
        clearMon();
        frameBegin();
        for (int j = 0; j < 3; j++) begin
            spiWord(16'(j + 1), 16, 1'b0, 1'b0, got);
            checkOutput($sformatf("3w miso%0d", j), got, (j == 0) ? 16'hAAA1 : (j == 1) ? 16'hBBB2 : 16'hCCC3);
        end
        frameEnd();
        checkOutput("3w rx count", rxDataQ.size(), 3);
        for (int j = 0; j < 3; j++) begin
            if (j < rxDataQ.size()) begin
                checkOutput($sformatf("3w rx%0d", j), rxDataQ[j], j + 1);
                checkOutput($sformatf("3w idx%0d", j), rxIdxQ[j], j);
            end
        end
`ifdef SPI_SLAVE_STATUS_EN
        checkOutput("3w frame_words", bus.frame_words_o, 3);
`endif

        // Asynchronous reset in the middle of a word.
        txFeed.push_back(16'h1111);
        txFeed.push_back(16'h2222);
        waitClocks(4);
        frameBegin();
        spiWord(16'hF0F0, 5, 1'b0, 1'b0, got);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset miso_oe",  bus.miso_oe_o,  0);
        checkOutput("midreset tx_ready", bus.tx_ready_o, 1);
        checkOutput("midreset rx_data",  bus.rx_data_o,  0);
        checkOutput("midreset word_idx", bus.word_idx_o, 0);
        checkOutput("midreset miso",     bus.miso_o,     0);
        bus.ssn_i = 1'b1;
        bus.sck_i = 1'b0;
        waitClocks(3);
        reset_n = 1'b1;
        waitClocks(3);
        txFeed.delete();
        txFeed.push_back(16'h4321);
        waitClocks(4);
        clearMon();
        frameBegin();
        spiWord(16'h8001, 16, 1'b0, 1'b0, got);
        frameEnd();
        checkOutput("postreset miso", got, 16'h4321);
        checkOutput("postreset rx count", rxDataQ.size(), 1);
        if (rxDataQ.size() > 0) checkOutput("postreset rx data", rxDataQ[0], 16'h8001);

        // Random jittered frames: 100 words in total.
        begin
            int sent;
            sent = 0;
            while (sent < 100) begin
                int n;
                int k;
                n = $urandom_range(1, 6);
                if (n > 100 - sent) n = 100 - sent;
                k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : n;
                for (int j = 0; j < n; j++) begin
                    mArr[j] = 16'($urandom);
                    tArr[j] = 16'($urandom);
                end
                for (int j = 0; j < k; j++) txFeed.push_back(tArr[j]);
                waitClocks(4);
                clearMon();
                frameBegin();
                for (int j = 0; j < n; j++) begin
                    spiWord(mArr[j], 16, 1'b1, 1'b0, got);
                    checkOutput($sformatf("rnd miso w%0d", sent + j), got, (j < k) ? tArr[j] : 16'h0000);
                end
                frameEnd();
                checkOutput($sformatf("rnd rx count @%0d", sent), rxDataQ.size(), n);
                for (int j = 0; j < n; j++) begin
                    if (j < rxDataQ.size()) begin
                        checkOutput($sformatf("rnd rx w%0d", sent + j), rxDataQ[j], mArr[j]);
                        checkOutput($sformatf("rnd idx w%0d", sent + j), rxIdxQ[j], j);
                    end
                end
                sent += n;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
